// File: rtl/mshr_replay_issue.sv
// mshr_replay_issue
//
// Drains the MSHR replay queue after a refill completes. Each queued
// secondary request is popped in order. Write-type commands fetch their
// store data from the store-data queue (SDQ). Every surviving request is
// then presented to the dcache pipeline as a replay, tagged with the way
// that the refill wrote. The SDQ slot of a write is returned once its
// replay is accepted, or once it is dropped because it was killed.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, start_way_en   refill-complete pulse and the refilled way (one-hot)
//   busy, done            session active / one-cycle drain pulse
//   q_deq_*, q_*          replay queue head handshake and fields
//   sdq_rd_en/addr/data   SDQ read port (data arrives one cycle after en)
//   rp_valid/ready, rp_*  replay request to the data/meta pipeline
//   sdq_free_valid/id     SDQ slot release
module mshr_replay_issue #(
    parameter int ADDR_W   = 40,
    parameter int TAG_W    = 9,
    parameter int SDQ_ID_W = 5,
    parameter int DATA_W   = 64,
    parameter int WAYS     = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                start,
    input  logic [WAYS-1:0]     start_way_en,
    output logic                busy,
    output logic                done,

    input  logic                q_deq_valid,
    output logic                q_deq_ready,
    input  logic [ADDR_W-1:0]   q_addr,
    input  logic [TAG_W-1:0]    q_tag,
    input  logic [4:0]          q_cmd,
    input  logic [2:0]          q_typ,
    input  logic                q_kill,
    input  logic                q_phys,
    input  logic [SDQ_ID_W-1:0] q_sdq_id,

    output logic                sdq_rd_en,
    output logic [SDQ_ID_W-1:0] sdq_rd_addr,
    input  logic [DATA_W-1:0]   sdq_rd_data,

    output logic                rp_valid,
    input  logic                rp_ready,
    output logic [ADDR_W-1:0]   rp_addr,
    output logic [TAG_W-1:0]    rp_tag,
    output logic [4:0]          rp_cmd,
    output logic [2:0]          rp_typ,
    output logic                rp_phys,
    output logic [WAYS-1:0]     rp_way_en,
    output logic [DATA_W-1:0]   rp_data,

    output logic                sdq_free_valid,
    output logic [SDQ_ID_W-1:0] sdq_free_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        DATA  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t              state;
    logic [WAYS-1:0]     way_en_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [TAG_W-1:0]    tag_r;
    logic [4:0]          cmd_r;
    logic [2:0]          typ_r;
    logic                kill_r;
    logic                phys_r;
    logic [SDQ_ID_W-1:0] sdq_id_r;
    logic [DATA_W-1:0]   data_r;
    logic                done_r;

    // Plain stores (M_XWR) and every AMO (cmd[3]) carry data in the SDQ.
    function automatic logic is_write(input logic [4:0] cmd);
        return (cmd == 5'h01) | cmd[3];
    endfunction

    logic head_pop;
    logic head_is_write;

    assign head_pop      = (state == POP) && q_deq_valid;
    assign head_is_write = is_write(q_cmd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            way_en_r <= '0;
            addr_r   <= '0;
            tag_r    <= '0;
            cmd_r    <= '0;
            typ_r    <= '0;
            kill_r   <= 1'b0;
            phys_r   <= 1'b0;
            sdq_id_r <= '0;
            data_r   <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        way_en_r <= start_way_en;
                        state    <= POP;
                    end
                end
                POP: begin
                    if (!q_deq_valid) begin
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        addr_r   <= q_addr;
                        tag_r    <= q_tag;
                        cmd_r    <= q_cmd;
                        typ_r    <= q_typ;
                        kill_r   <= q_kill;
                        phys_r   <= q_phys;
                        sdq_id_r <= q_sdq_id;
                        if (head_is_write) begin
                            // Killed writes still go through DATA so the
                            // SDQ slot they hold gets released.
                            state <= DATA;
                        end else if (q_kill) begin
                            state <= POP;
                        end else begin
                            data_r <= '0;
                            state  <= ISSUE;
                        end
                    end
                end
                DATA: begin
                    data_r <= sdq_rd_data;
                    state  <= kill_r ? POP : ISSUE;
                end
                ISSUE: begin
                    if (rp_ready) begin
                        state <= POP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register so that an asynchronous
    // reset drops them immediately.
    assign busy        = (state != IDLE);
    assign done        = done_r;
    assign q_deq_ready = (state == POP);

    assign sdq_rd_en   = head_pop && head_is_write;
    assign sdq_rd_addr = sdq_rd_en ? q_sdq_id : '0;

    assign rp_valid  = (state == ISSUE);
    assign rp_addr   = addr_r;
    assign rp_tag    = tag_r;
    assign rp_cmd    = cmd_r;
    assign rp_typ    = typ_r;
    assign rp_phys   = phys_r;
    assign rp_way_en = way_en_r;
    assign rp_data   = data_r;

    // Only un-killed entries reach ISSUE, so the slot is released there on
    // acceptance, or in DATA when the entry was killed.
    assign sdq_free_valid = ((state == DATA) && kill_r) ||
                            ((state == ISSUE) && rp_ready && is_write(cmd_r));
    assign sdq_free_id    = sdq_free_valid ? sdq_id_r : '0;

endmodule

// File: tb/tb_mshr_replay_issue.sv
module tb_mshr_replay_issue;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  start_way_en;
    logic        busy;
    logic        done;
    logic        q_deq_valid;
    logic        q_deq_ready;
    logic [39:0] q_addr;
    logic [8:0]  q_tag;
    logic [4:0]  q_cmd;
    logic [2:0]  q_typ;
    logic        q_kill;
    logic        q_phys;
    logic [4:0]  q_sdq_id;
    logic        sdq_rd_en;
    logic [4:0]  sdq_rd_addr;
    logic [63:0] sdq_rd_data;
    logic        rp_valid;
    logic        rp_ready;
    logic [39:0] rp_addr;
    logic [8:0]  rp_tag;
    logic [4:0]  rp_cmd;
    logic [2:0]  rp_typ;
    logic        rp_phys;
    logic [3:0]  rp_way_en;
    logic [63:0] rp_data;
    logic        sdq_free_valid;
    logic [4:0]  sdq_free_id;

    mshr_replay_issue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_way_en   (start_way_en),
        .busy           (busy),
        .done           (done),
        .q_deq_valid    (q_deq_valid),
        .q_deq_ready    (q_deq_ready),
        .q_addr         (q_addr),
        .q_tag          (q_tag),
        .q_cmd          (q_cmd),
        .q_typ          (q_typ),
        .q_kill         (q_kill),
        .q_phys         (q_phys),
        .q_sdq_id       (q_sdq_id),
        .sdq_rd_en      (sdq_rd_en),
        .sdq_rd_addr    (sdq_rd_addr),
        .sdq_rd_data    (sdq_rd_data),
        .rp_valid       (rp_valid),
        .rp_ready       (rp_ready),
        .rp_addr        (rp_addr),
        .rp_tag         (rp_tag),
        .rp_cmd         (rp_cmd),
        .rp_typ         (rp_typ),
        .rp_phys        (rp_phys),
        .rp_way_en      (rp_way_en),
        .rp_data        (rp_data),
        .sdq_free_valid (sdq_free_valid),
        .sdq_free_id    (sdq_free_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Replay queue and SDQ models.
    logic [39:0] qa [8];
    logic [8:0]  qt [8];
    logic [4:0]  qc [8];
    logic [2:0]  qy [8];
    logic        qk [8];
    logic        qp [8];
    logic [4:0]  qs [8];
    int          qn;
    int          head;
    logic [63:0] sdq_mem [32];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_head();
        if (head < qn) begin
            q_deq_valid = 1'b1;
            q_addr      = qa[head];
            q_tag       = qt[head];
            q_cmd       = qc[head];
            q_typ       = qy[head];
            q_kill      = qk[head];
            q_phys      = qp[head];
            q_sdq_id    = qs[head];
        end else begin
            q_deq_valid = 1'b0;
            q_addr      = '0;
            q_tag       = '0;
            q_cmd       = '0;
            q_typ       = '0;
            q_kill      = 1'b0;
            q_phys      = 1'b0;
            q_sdq_id    = '0;
        end
    endtask

    task automatic push(input logic [39:0] a, input logic [8:0] t, input logic [4:0] c,
                        input logic [2:0] y, input logic k, input logic p, input logic [4:0] s);
        qa[qn] = a; qt[qn] = t; qc[qn] = c; qy[qn] = y;
        qk[qn] = k; qp[qn] = p; qs[qn] = s;
        qn++;
        drive_head();
    endtask

    task automatic clear_queue();
        qn   = 0;
        head = 0;
        drive_head();
    endtask

    // Advance one clock; the queue pops and the SDQ answers exactly as the
    // real structures would, based on the handshake seen before the edge.
    task automatic step();
        logic       pop;
        logic       rd;
        logic [4:0] ra;
        pop = q_deq_ready && q_deq_valid;
        rd  = sdq_rd_en;
        ra  = sdq_rd_addr;
        @(posedge clk);
        #1;
        if (pop) head++;
        if (rd) sdq_rd_data = sdq_mem[ra];
        drive_head();
        #1;
    endtask

    task automatic kick(input logic [3:0] way);
        start        = 1'b1;
        start_way_en = way;
        step();
        start        = 1'b0;
        start_way_en = 4'b0000;
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        start_way_en = 4'b0000;
        rp_ready     = 1'b0;
        sdq_rd_data  = '0;
        for (int i = 0; i < 32; i++) sdq_mem[i] = 64'h1111_0000_0000_0000 + 64'(i);
        sdq_mem[7] = 64'hDEADBEEF_CAFEF00D;
        sdq_mem[9] = 64'h0123_4567_89AB_CDEF;
        clear_queue();

        // 1: reset values, then an empty session.
        step();
        step();
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_qrdy",  64'(q_deq_ready), 64'd0);
        chk("rst_rden",  64'(sdq_rd_en), 64'd0);
        chk("rst_rpv",   64'(rp_valid), 64'd0);
        chk("rst_free",  64'(sdq_free_valid), 64'd0);
        chk("rst_addr",  64'(rp_addr), 64'd0);
        chk("rst_data",  rp_data, 64'd0);
        reset_n = 1'b1;
        step();
        step();
        chk("idle_busy", 64'(busy), 64'd0);
        kick(4'b0100);
        chk("e_busy1",   64'(busy), 64'd1);
        chk("e_done1",   64'(done), 64'd0);
        chk("e_way",     64'(rp_way_en), 64'h4);
        step();
        chk("e_busy2",   64'(busy), 64'd0);
        chk("e_done2",   64'(done), 64'd1);
        step();
        chk("e_done3",   64'(done), 64'd0);

        // 2: three loads back to back.
        clear_queue();
        push(40'h100, 9'd1, 5'h00, 3'd3, 1'b0, 1'b0, 5'd0);
        push(40'h200, 9'd2, 5'h00, 3'd3, 1'b0, 1'b0, 5'd0);
        push(40'h300, 9'd3, 5'h00, 3'd3, 1'b0, 1'b0, 5'd0);
        rp_ready = 1'b1;
        kick(4'b0010);
        for (int i = 0; i < 3; i++) begin
            chk("ld_pop_rdy", 64'(q_deq_ready), 64'd1);
            chk("ld_pop_rpv", 64'(rp_valid), 64'd0);
            step();
            chk("ld_rpv",  64'(rp_valid), 64'd1);
            chk("ld_tag",  64'(rp_tag), 64'(i + 1));
            chk("ld_addr", 64'(rp_addr), 64'((i + 1) * 256));
            chk("ld_way",  64'(rp_way_en), 64'h2);
            chk("ld_data", rp_data, 64'd0);
            chk("ld_free", 64'(sdq_free_valid), 64'd0);
            step();
        end
        chk("ld_empty_busy", 64'(busy), 64'd1);
        step();
        chk("ld_done", 64'(done), 64'd1);
        chk("ld_idle", 64'(busy), 64'd0);

        // 3: single store through the SDQ.
        clear_queue();
        push(40'h12_3456_7890, 9'd20, 5'h01, 3'd3, 1'b0, 1'b1, 5'd7);
        kick(4'b1000);
        chk("st_rden",  64'(sdq_rd_en), 64'd1);
        chk("st_rdadr", 64'(sdq_rd_addr), 64'd7);
        step();
        chk("st_data_rpv",  64'(rp_valid), 64'd0);
        chk("st_data_free", 64'(sdq_free_valid), 64'd0);
        chk("st_data_busy", 64'(busy), 64'd1);
        step();
        chk("st_rpv",   64'(rp_valid), 64'd1);
        chk("st_data",  rp_data, 64'hDEADBEEF_CAFEF00D);
        chk("st_addr",  64'(rp_addr), 64'h12_3456_7890);
        chk("st_cmd",   64'(rp_cmd), 64'h01);
        chk("st_typ",   64'(rp_typ), 64'd3);
        chk("st_phys",  64'(rp_phys), 64'd1);
        chk("st_way",   64'(rp_way_en), 64'h8);
        chk("st_free",  64'(sdq_free_valid), 64'd1);
        chk("st_fid",   64'(sdq_free_id), 64'd7);
        step();
        chk("st_free_once", 64'(sdq_free_valid), 64'd0);
        step();
        chk("st_done", 64'(done), 64'd1);

        // 4: AMO-class store stalled for five cycles.
        clear_queue();
        push(40'hAB_CDEF_0000, 9'd33, 5'h08, 3'd2, 1'b0, 1'b0, 5'd9);
        rp_ready = 1'b0;
        kick(4'b0001);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stl_rpv",  64'(rp_valid), 64'd1);
            chk("stl_addr", 64'(rp_addr), 64'hAB_CDEF_0000);
            chk("stl_tag",  64'(rp_tag), 64'd33);
            chk("stl_cmd",  64'(rp_cmd), 64'h08);
            chk("stl_data", rp_data, 64'h0123_4567_89AB_CDEF);
            chk("stl_free", 64'(sdq_free_valid), 64'd0);
            chk("stl_qrdy", 64'(q_deq_ready), 64'd0);
            step();
        end
        rp_ready = 1'b1;
        #1;
        chk("stl_acc_free", 64'(sdq_free_valid), 64'd1);
        chk("stl_acc_fid",  64'(sdq_free_id), 64'd9);
        step();
        chk("stl_post_free", 64'(sdq_free_valid), 64'd0);
        chk("stl_post_rpv",  64'(rp_valid), 64'd0);
        step();
        chk("stl_done", 64'(done), 64'd1);

        // 5: killed store, load, killed load, load.
        clear_queue();
        push(40'h500, 9'd4, 5'h01, 3'd3, 1'b1, 1'b0, 5'd3);
        push(40'h600, 9'd5, 5'h00, 3'd3, 1'b0, 1'b0, 5'd0);
        push(40'h700, 9'd6, 5'h00, 3'd3, 1'b1, 1'b0, 5'd0);
        push(40'h800, 9'd7, 5'h00, 3'd3, 1'b0, 1'b0, 5'd0);
        kick(4'b0010);
        chk("k_rden",  64'(sdq_rd_en), 64'd1);
        chk("k_rdadr", 64'(sdq_rd_addr), 64'd3);
        step();
        chk("k_data_free", 64'(sdq_free_valid), 64'd1);
        chk("k_data_fid",  64'(sdq_free_id), 64'd3);
        chk("k_data_rpv",  64'(rp_valid), 64'd0);
        step();
        chk("k_pop_rpv",   64'(rp_valid), 64'd0);
        chk("k_pop_free",  64'(sdq_free_valid), 64'd0);
        step();
        chk("k_ld_rpv",  64'(rp_valid), 64'd1);
        chk("k_ld_tag",  64'(rp_tag), 64'd5);
        step();
        chk("k_kl_rpv",  64'(rp_valid), 64'd0);
        step();
        chk("k_kl_drop_rpv",  64'(rp_valid), 64'd0);
        chk("k_kl_drop_qrdy", 64'(q_deq_ready), 64'd1);
        chk("k_kl_drop_free", 64'(sdq_free_valid), 64'd0);
        step();
        chk("k_ld2_rpv", 64'(rp_valid), 64'd1);
        chk("k_ld2_tag", 64'(rp_tag), 64'd7);
        step();
        step();
        chk("k_done", 64'(done), 64'd1);

        // 6: asynchronous reset while a store waits in ISSUE.
        clear_queue();
        push(40'h900, 9'd8, 5'h01, 3'd3, 1'b0, 1'b0, 5'd7);
        push(40'hA00, 9'd9, 5'h00, 3'd3, 1'b0, 1'b0, 5'd0);
        rp_ready = 1'b0;
        kick(4'b0100);
        step();
        step();
        chk("ar_rpv_pre", 64'(rp_valid), 64'd1);
        rp_ready = 1'b1;
        #1;
        chk("ar_free_pre", 64'(sdq_free_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("ar_rpv",  64'(rp_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_free", 64'(sdq_free_valid), 64'd0);
        chk("ar_data", rp_data, 64'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_idle_busy", 64'(busy), 64'd0);
            chk("ar_idle_qrdy", 64'(q_deq_ready), 64'd0);
            chk("ar_idle_rpv",  64'(rp_valid), 64'd0);
        end
        chk("ar_q_left", 64'(q_deq_valid), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
